// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared defaults and helpers for the scoreboarded register file
// Purpose: default widths, the address-width derivation and the counter ceiling
// used by regfile_sb and regfile_sb_ctr. No ports.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;
  localparam int CNT_W_DEF  = 2;

  // Address width for n entries; never narrower than one bit.
  function automatic int aw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Largest value a w-bit outstanding-write counter may hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX_DEF = cnt_max(CNT_W_DEF);

endpackage

// File: rtl/regfile_sb_ctr.sv
// rtl/regfile_sb_ctr.sv - per-register saturating outstanding-write counter
// Purpose: counts issued-but-not-completed writes to one register.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   inc         one issue to this register this cycle
//   dec         number of completions to this register this cycle (0..NWR)
//   hold        freeze the count
//   cnt         current count
//   underflow   completions exceeded count + issue this cycle (count clamps at 0)
module regfile_sb_ctr
  import regfile_sb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  // Wide enough that cnt + inc never wraps and the compare against dec is exact.
  localparam int SW = CNT_W + DEC_W + 1;
  localparam logic [SW-1:0] TOP = SW'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    up, dn;

  always_comb begin
    up        = SW'(cnt_q) + SW'(inc);
    dn        = SW'(dec);
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (!hold) begin
      if (up < dn) begin
        cnt_d     = '0;
        underflow = 1'b1;
      end else if ((up - dn) > TOP) begin
        cnt_d = CNT_W'(TOP);
      end else begin
        cnt_d = CNT_W'(up - dn);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with pending-write scoreboard
// Purpose: NRD combinational read ports with write-through bypass, NWR write-back
// ports (higher index wins on collision) and per-register outstanding-write
// counters producing rd_busy and iss_ready. Register 0 reads zero, never busy.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   hold                suppresses all writes and issues this cycle
//   rd_addr/rd_data     read ports, port i at slice i
//   rd_busy             source register has an outstanding write
//   iss_val/iss_dst     issuing instruction and its destination
//   iss_ready           issue accepted (destination counter not full)
//   wr_en/wr_addr/wr_data  write-back ports
//   err                 sticky: a write-back found its counter already at 0
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int AW     = aw_of(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_val,
  input  logic [AW-1:0]         iss_dst,
  output logic                  iss_ready,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  output logic                  err
);

  localparam int DEC_W = aw_of(NWR + 1);
  localparam int CW    = CNT_W + DEC_W;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(cnt_max(CNT_W));

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt [NREGS];
  logic [NREGS-1:1]  inc, unf;
  logic [DEC_W-1:0]  dec [1:NREGS-1];
  logic [NWR-1:0]    we_eff;
  logic              iss_eff;

  always_comb begin
    for (int j = 0; j < NWR; j++)
      we_eff[j] = wr_en[j] & ~hold & (wr_addr[j*AW +: AW] != '0);
  end

  // Conservative: a completion in this same cycle does not free a full counter.
  assign iss_ready = (iss_dst == '0) | (cnt[iss_dst] != CNT_TOP);
  assign iss_eff   = iss_val & iss_ready & ~hold & (iss_dst != '0);

  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      inc[r] = iss_eff & (iss_dst == AW'(r));
      dec[r] = '0;
      for (int j = 0; j < NWR; j++)
        if (we_eff[j] && wr_addr[j*AW +: AW] == AW'(r)) dec[r] = dec[r] + DEC_W'(1);
    end
  end

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_ctr
    regfile_sb_ctr #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc[r]),
      .dec       (dec[r]),
      .hold      (hold),
      .cnt       (cnt[r]),
      .underflow (unf[r])
    );
  end

  // Ascending port order lets the highest-index writer land last.
  always_comb begin
    for (int r = 0; r < NREGS; r++) rf_d[r] = rf_q[r];
    for (int j = 0; j < NWR; j++)
      if (we_eff[j]) rf_d[wr_addr[j*AW +: AW]] = wr_data[j*DATA_W +: DATA_W];
    err_d = err_q | (|unf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= rf_d[r];
      err_q <= err_d;
    end
  end

  assign err = err_q;

  // Bypass the highest-index same-cycle writer; each hit also credits a
  // completion so a consumer waiting on it is released in the same cycle.
  always_comb begin
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic [DEC_W-1:0]  c;
    rd_data = '0;
    rd_busy = '0;
    a = '0;
    d = '0;
    c = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      d = rf_q[a];
      c = '0;
      for (int j = 0; j < NWR; j++) begin
        if (we_eff[j] && wr_addr[j*AW +: AW] == a) begin
          d = wr_data[j*DATA_W +: DATA_W];
          c = c + DEC_W'(1);
        end
      end
      if (a == '0) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                  = 1'b0;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = d;
        rd_busy[i]                  = CW'(cnt[a]) > CW'(c);
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset, hold, iss_val, iss_ready, err;
  logic [9:0]  rd_addr, wr_addr;
  logic [63:0] rd_data, wr_data;
  logic [1:0]  rd_busy, wr_en;
  logic [4:0]  iss_dst;
  int          checks = 0;
  int          failures = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset), .hold(hold),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_val(iss_val), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hold = 0; iss_val = 0; iss_dst = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*5 +: 5] = a;
    wr_data[j*32 +: 32] = d;
  endtask

  task automatic issue(input logic [4:0] dst);
    iss_val = 1; iss_dst = dst;
    tick();
    iss_val = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); rd(0, 0);
    tick(); tick();
    reset = 0;
    for (int r = 0; r < 32; r++) begin
      rd(5'(r), 5'(31 - r));
      #1;
      checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_data r=%0d got=%h exp=0", r, rd_data); end
      checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL reset_busy r=%0d got=%b exp=00", r, rd_busy); end
    end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL reset_iss_ready got=%b exp=1", iss_ready); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_issue_bypass();
    idle(); rd(5, 0);
    iss_val = 1; iss_dst = 5; #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL ib_ready got=%b exp=1", iss_ready); end
    tick(); iss_val = 0; #1;
    checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL ib_busy got=%b exp=1", rd_busy[0]); end
    wr(0, 5, 32'hDEADBEEF); #1;
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL ib_bypass got=%h exp=deadbeef", rd_data[31:0]); end
    checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL ib_bypass_busy got=%b exp=0", rd_busy[0]); end
    tick(); idle(); #1;
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL ib_stored got=%h exp=deadbeef", rd_data[31:0]); end
    checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL ib_cnt0 got=%b exp=0", rd_busy[0]); end
  endtask

  task automatic test_saturate();
    idle(); rd(3, 0);
    issue(3); issue(3); issue(3);
    iss_val = 1; iss_dst = 3; #1;
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL sat_full got=%b exp=0", iss_ready); end
    iss_dst = 4; #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_other got=%b exp=1", iss_ready); end
    iss_dst = 3; wr(1, 3, 32'h33); #1;
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL sat_conservative got=%b exp=0", iss_ready); end
    checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL sat_busy3 got=%b exp=1", rd_busy[0]); end
    tick(); idle(); iss_dst = 3; #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_release got=%b exp=1", iss_ready); end
    wr(1, 3, 32'h34); tick(); idle(); #1;
    checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL sat_busy1 got=%b exp=1", rd_busy[0]); end
    wr(1, 3, 32'h35); tick(); idle(); #1;
    checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL sat_drained got=%b exp=0", rd_busy[0]); end
    checks++; if (rd_data[31:0] !== 32'h35) begin failures++; $display("FAIL sat_data got=%h exp=35", rd_data[31:0]); end
  endtask

  task automatic test_hold();
    idle();
    issue(10);
    rd(9, 10);
    hold = 1; wr(0, 9, 32'h12345678); wr(1, 10, 32'h5555); iss_val = 1; iss_dst = 9; #1;
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL hold_nobypass got=%h exp=0", rd_data); end
    checks++; if (rd_busy !== 2'b10) begin failures++; $display("FAIL hold_busy got=%b exp=10", rd_busy); end
    tick(); idle(); #1;
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL hold_rf got=%h exp=0", rd_data); end
    checks++; if (rd_busy !== 2'b10) begin failures++; $display("FAIL hold_cnt got=%b exp=10", rd_busy); end
    wr(1, 10, 32'h5555); tick(); idle();
    rd(0, 0); wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hEEEEEEEE); iss_val = 1; iss_dst = 0; #1;
    checks++; if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin failures++; $display("FAIL r0_bypass got=%h/%b exp=0/00", rd_data, rd_busy); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", iss_ready); end
    tick(); idle(); #1;
    checks++; if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin failures++; $display("FAIL r0_stored got=%h/%b exp=0/00", rd_data, rd_busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL hold_err got=%b exp=0", err); end
  endtask

  task automatic test_collision();
    idle(); rd(8, 7);
    issue(8); issue(8);
    wr(0, 8, 32'hAAAA0000); wr(1, 8, 32'hBBBB0000); #1;
    checks++; if (rd_data[31:0] !== 32'hBBBB0000) begin failures++; $display("FAIL col2_bypass got=%h exp=bbbb0000", rd_data[31:0]); end
    checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL col2_busy got=%b exp=0", rd_busy[0]); end
    tick(); idle(); #1;
    checks++; if (rd_data[31:0] !== 32'hBBBB0000) begin failures++; $display("FAIL col2_stored got=%h exp=bbbb0000", rd_data[31:0]); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL col2_err got=%b exp=0", err); end
    issue(7);
    wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222); #1;
    checks++; if (rd_data[63:32] !== 32'h22222222) begin failures++; $display("FAIL col1_bypass got=%h exp=22222222", rd_data[63:32]); end
    tick(); idle(); #1;
    checks++; if (rd_data[63:32] !== 32'h22222222) begin failures++; $display("FAIL col1_stored got=%h exp=22222222", rd_data[63:32]); end
    checks++; if (rd_busy[1] !== 1'b0) begin failures++; $display("FAIL col1_sat got=%b exp=0", rd_busy[1]); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL col1_err got=%b exp=1", err); end
  endtask

  task automatic test_reset_pending();
    idle(); rd(2, 8);
    issue(2); issue(2);
    reset = 1; wr(0, 2, 32'hAAAA5555); iss_val = 1; iss_dst = 2;
    tick(); reset = 0; idle(); iss_dst = 2; #1;
    checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL rstp_busy got=%b exp=00", rd_busy); end
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL rstp_data got=%h exp=0", rd_data); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rstp_err got=%b exp=0", err); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL rstp_ready got=%b exp=1", iss_ready); end
  endtask

  initial begin
    reset = 1; idle(); rd_addr = 0;
    test_reset();
    test_issue_bypass();
    test_saturate();
    test_hold();
    test_collision();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with an integrated per-register pending-write scoreboard. It is the next-generation replacement for the two-read/one-write file in the decode stage. It provides NRD combinational read ports with write-through bypass and NWR independent write-back ports, for example ALU and load return. Per-register outstanding-write counters drive decode's RAW-hazard stall and issue back-pressure, so the stall no longer has to be reconstructed from pipeline-stage compares.

## Interface
Parameters:
- DATA_W, 32, register width
- NREGS, 32, number of architectural registers; register 0 hardwired to zero
- AW, $clog2(NREGS), register address width (derived, not overridden)
- NRD, 2, read ports
- NWR, 2, write-back ports; higher index has priority on data collision
- CNT_W, 2, width of per-register outstanding-write counter; max pending = 2^CNT_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  pipeline stall; when 1, suppresses every write and every issue this cycle
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*DATA_W  read data (combinational)
- rd_busy  out  NRD  1 = source register still has an uncompleted write (consumer must stall)
- iss_val  in  1  instruction with a destination is issuing this cycle
- iss_dst  in  AW  destination register of issuing instruction
- iss_ready  out  1  issue accepted this cycle (combinational)
- wr_en  in  NWR  write-back strobe per port
- wr_addr  in  NWR*AW  write-back address per port
- wr_data  in  NWR*DATA_W  write-back data per port
- err  out  1  sticky: a write-back arrived for a register whose counter was 0

## Operation
- Effective write: wr_en[j] & !hold & wr_addr[j]!=0. Effective issue: iss_val & iss_ready & !hold & iss_dst!=0.
- Storage: on an effective write, rf[wr_addr[j]] <= wr_data[j]. If several ports hit the same address, the highest j wins.
- Read: rd_data[i] = 0 if rd_addr[i]==0. Otherwise it is the data of the highest-j effective write to rd_addr[i] this cycle (bypass), else rf[rd_addr[i]].
- Counter cnt[r] (CNT_W bits) is updated each cycle: next = cnt + (effective issue to r) − (number of effective writes to r).
  - Each write port hitting r counts as one completion.
  - The counter saturates at 0 on underflow; the underflow sets err.
- rd_busy[i] = (cnt[rd_addr[i]] − completions to rd_addr[i] this cycle) != 0.
  - A same-cycle completion therefore unblocks the consumer, and its data is bypassed.
  - Register 0 is never busy.
- iss_ready = (iss_dst==0) | (cnt[iss_dst] != 2^CNT_W−1). The check is conservative: same-cycle completions are ignored.
- Issue and completion to the same register in one cycle leave the counter unchanged.
- Issuing the destination and reading it as a source in the same cycle: rd_busy reflects the pre-issue count, so the instruction does not stall on itself.
- hold=1: rf and cnt are frozen. rd_data and rd_busy are still computed, but without bypass or completion credit, because no write is effective.

## Timing
- Reads and rd_busy: combinational from rd_addr, wr_* and current state, with zero latency.
- Write visible through rf from the cycle after the edge, and through bypass in the same cycle.
- Counter change visible in rd_busy and iss_ready the cycle after the edge.
- Reset (synchronous, any cycle, including with writes or issues pending):
  - all rf entries = 0, all cnt = 0, err = 0;
  - same-cycle writes and issues are discarded;
  - in the cycle after reset, rd_data = 0, rd_busy = 0, iss_ready = 1.

## Structure
- Shared package regfile_sb_pkg holds:
  - DATA_W and NREGS defaults;
  - the AW derivation function;
  - the CNT_W default;
  - the constant for counter max.
- Sub-module regfile_sb_ctr: one CNT_W saturating up/down counter. Inputs are inc, a dec count (0..NWR) and hold. Outputs are the count and an underflow pulse. It is instantiated NREGS−1 times in a generate loop.
- Top level holds the storage array, the priority write mux, the bypass mux and the err register.

## Test plan
- Reset, then read all registers → rd_data=0, rd_busy=0, iss_ready=1, err=0.
- Issue r5, next cycle read r5 → rd_busy=1. Write-back port 0, r5=0xDEADBEEF, in the same cycle as the read → rd_data=0xDEADBEEF, rd_busy=0. Next cycle cnt[r5]=0.
- Ports 0 and 1 both write r7 (0x11111111 and 0x22222222) in one cycle → bypass and stored value are 0x22222222. cnt[r7] drops by 2 and saturates at 0 if it was 1; err=1 in that case.
- CNT_W=2: issue r3 three times → iss_ready=0 for dst r3 and 1 for dst r4. One completion → iss_ready=1 the next cycle.
- hold=1 with wr_en=1 to r9 and iss_val=1 to r9 → rf[r9] and cnt[r9] unchanged, no bypass. Write to r0 → r0 still reads 0 and is never busy.
- Assert reset while cnt[r2]=2 and a write to r2 is pending → next cycle rd_busy=0, rf[r2]=0, err=0.
